// File: rtl/env_vca_pkg.sv
// Shared definitions for the envelope VCA: FSM states, fixed-point and
// saturation constants. Falls back to 16-bit defaults when the global
// BITS/FPWIDTH defines are not supplied by the including build.
`ifndef BITS
`define BITS 16
`endif
`ifndef FPWIDTH
`define FPWIDTH 16
`endif

package env_vca_pkg;

  localparam int unsigned BITS    = `BITS;
  localparam int unsigned FPWIDTH = `FPWIDTH;

  // Envelope level that represents a gain of exactly 1.0
  localparam logic [BITS-1:0] UNITY_GAIN = BITS'(1) << (FPWIDTH - 1);

  // Signed output limits for a BITS-wide sample
  localparam logic signed [BITS-1:0] SAT_MAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] SAT_MIN = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ENV_VCA_IDLE   = 2'd0,
    ENV_VCA_SMOOTH = 2'd1,
    ENV_VCA_MUL    = 2'd2,
    ENV_VCA_OUT    = 2'd3
  } env_vca_state_e;

endpackage

// File: rtl/env_vca_sat_clip.sv
// sat_clip: combinational signed clamp from IN_W bits down to OUT_W bits.
// Shared with the mixer; expects IN_W > OUT_W.
module sat_clip #(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);

  logic [IN_W-OUT_W:0] hi;

  // In range when all bits above the output sign bit agree with it
  always_comb begin
    hi = in_i[IN_W-1:OUT_W-1];
    if (hi == '0 || hi == '1) begin
      out_o = in_i[OUT_W-1:0];
    end else if (in_i[IN_W-1]) begin
      out_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/env_vca.sv
// env_vca: envelope-controlled amplifier. Latches one audio sample and
// envelope level per strobe, optionally slews the envelope, multiplies,
// saturates and emits the result three cycles after the strobe.
// Build option: define ENV_VCA_SMOOTH_EN to enable the one-pole envelope
// smoother; otherwise the envelope follows its input in hard steps.
module env_vca
  import env_vca_pkg::*;
#(
  parameter int unsigned SLEW_SHIFT = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            sample_valid,
  input  logic [BITS-1:0] audio_in,
  input  logic [BITS-1:0] env_in,
  output logic [BITS-1:0] out,
  output logic            out_valid,
  output logic            overrun
);

  if (SLEW_SHIFT > BITS - 1) begin : g_bad_slew
    $error("env_vca: SLEW_SHIFT out of range");
  end

  env_vca_state_e          state_q, state_d;
  logic signed [BITS-1:0]  aud_q, aud_d;
  logic [BITS-1:0]         tgt_q, tgt_d;
  logic [BITS-1:0]         env_q, env_d;
  logic signed [BITS-1:0]  out_q, out_d;
  logic                    ovr_q, ovr_d;

  logic [BITS-1:0]         env_next;
  logic signed [2*BITS:0]  prod;
  logic signed [2*BITS:0]  scaled;
  logic signed [BITS-1:0]  clip_out;

`ifdef ENV_VCA_SMOOTH_EN
  logic signed [BITS:0]    diff;
  logic signed [BITS:0]    step;

  // One-pole slew toward the target with a +/-1 floor so it always lands exactly
  always_comb begin
    diff = $signed({1'b0, tgt_q}) - $signed({1'b0, env_q});
    step = diff >>> SLEW_SHIFT;
    if (step == '0 && diff != '0) begin
      step = diff[BITS] ? '1 : (BITS+1)'(1);
    end
    // Result always lies between env_q and tgt_q, so modular BITS-wide add is exact
    env_next = env_q + step[BITS-1:0];
  end
`else
  // Hard steps: envelope jumps straight to the latched target
  always_comb begin
    env_next = tgt_q;
  end
`endif

  // Signed audio times unsigned envelope, rescaled so UNITY_GAIN is 1.0
  always_comb begin
    prod   = (2*BITS+1)'(aud_q) * (2*BITS+1)'($signed({1'b0, env_q}));
    scaled = prod >>> (FPWIDTH - 1);
  end

  sat_clip #(
    .IN_W  (2*BITS+1),
    .OUT_W (BITS)
  ) u_clip (
    .in_i  (scaled),
    .out_o (clip_out)
  );

  // Next-state and datapath load control; everything holds while ena is low
  always_comb begin
    state_d = state_q;
    aud_d   = aud_q;
    tgt_d   = tgt_q;
    env_d   = env_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    if (ena) begin
      unique case (state_q)
        ENV_VCA_IDLE: begin
          if (sample_valid) begin
            aud_d   = audio_in;
            tgt_d   = env_in;
            state_d = ENV_VCA_SMOOTH;
          end
        end
        ENV_VCA_SMOOTH: begin
          env_d   = env_next;
          state_d = ENV_VCA_MUL;
        end
        ENV_VCA_MUL: begin
          // Result register loads on the way into OUT so it is valid alongside the pulse
          out_d   = clip_out;
          state_d = ENV_VCA_OUT;
        end
        ENV_VCA_OUT: begin
          state_d = ENV_VCA_IDLE;
        end
        default: state_d = ENV_VCA_IDLE;
      endcase
      if (sample_valid && state_q != ENV_VCA_IDLE) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENV_VCA_IDLE;
      aud_q   <= '0;
      tgt_q   <= '0;
      env_q   <= '0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aud_q   <= aud_d;
      tgt_q   <= tgt_d;
      env_q   <= env_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = ena && (state_q == ENV_VCA_OUT);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_env_vca.sv
// Scoreboard bench for env_vca: stimulus pushes expected (value, cycle)
// pairs, a negedge monitor pops and compares on every out_valid.
module tb_env_vca;
  import env_vca_pkg::*;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic            sample_valid;
  logic [BITS-1:0] audio_in;
  logic [BITS-1:0] env_in;
  logic [BITS-1:0] out;
  logic            out_valid;
  logic            overrun;

  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

`ifdef ENV_VCA_SMOOTH_EN
  localparam int OVR_EXP   = 1000;  // env 0 -> 8192, 4000*8192>>15
  localparam int AFTER_EXP = 1750;  // env 8192 -> 14336, 4000*14336>>15
  localparam int FINAL_EXP = 125;   // env 0 -> 4096, 1000*4096>>15
`else
  localparam int OVR_EXP   = 4000;
  localparam int AFTER_EXP = 4000;
  localparam int FINAL_EXP = 500;
`endif

  env_vca #(.SLEW_SHIFT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .env_in       (env_in),
    .out          (out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe one sample and expect its result lat cycles later
  task automatic send(input int aud, input int env, input int exp, input int lat);
    audio_in     = BITS'(aud);
    env_in       = BITS'(env);
    sample_valid = 1'b1;
    sb.push_back('{exp, cyc + lat});
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Monitor: every out_valid must match the head of the scoreboard
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid: got out=%0d with nothing expected (cycle %0d)",
                 $signed(out), cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ($signed(out) != e.val || cyc != e.cyc) begin
          fails++;
          $display("FAIL out_value: got %0d at cycle %0d, expected %0d at cycle %0d",
                   $signed(out), cyc, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    ena          = 1'b1;
    sample_valid = 1'b1;
    audio_in     = BITS'(1000);
    env_in       = BITS'(16384);
    tick();
    sample_valid = 1'b0;
    tick();
    check("reset_out", int'($signed(out)), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b1;
    tick();

`ifdef ENV_VCA_SMOOTH_EN
    // Slew 0 -> 4096 -> 7168 -> 9472 seen through a fixed audio level
    send(4000, 16384, 500, 3);
    send(4000, 16384, 875, 3);
    send(4000, 16384, 1156, 3);
    // Convergence: full-scale negative audio makes out = -env_cur
    do_reset();
    send(-32768, 3, -1, 3);
    send(-32768, 3, -2, 3);
    send(-32768, 3, -3, 3);
    send(-32768, 3, -3, 3);
    send(-32768, 0, -2, 3);
    send(-32768, 0, -1, 3);
    send(-32768, 0, 0, 3);
    do_reset();
`else
    send(1000, 16384, 500, 3);
    send(-1000, 16384, -500, 3);
    send(30000, 65535, 32767, 3);
    send(-32768, 32767, -32767, 3);
    send(-30000, 65535, -32768, 3);
`endif

    // Overrun plus ena stall: strobes at N and N+1, ena low N+2..N+6
    check("overrun_before", int'(overrun), 0);
    audio_in     = BITS'(4000);
    env_in       = BITS'(32768);
    sample_valid = 1'b1;
    sb.push_back('{OVR_EXP, cyc + 8});
    tick();
    audio_in     = BITS'(1234);
    env_in       = BITS'(1234);
    tick();
    sample_valid = 1'b0;
    ena          = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    repeat (3) tick();
    check("overrun_set", int'(overrun), 1);
    send(4000, 32768, AFTER_EXP, 3);
    check("overrun_sticky", int'(overrun), 1);

    // Reset asserted while the sample sits in MUL: no pulse may follow
    audio_in     = BITS'(1000);
    env_in       = BITS'(16384);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("midreset_overrun", int'(overrun), 0);
    check("midreset_out", int'($signed(out)), 0);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("midreset_out_hold", int'($signed(out)), 0);
    check("midreset_out_valid", int'(out_valid), 0);

    send(1000, 16384, FINAL_EXP, 3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
